// File: rtl/idct_block_loader.sv
// rtl/idct_block_loader.sv - ping-pong block assembler feeding the IDCT core
// Collects 64 coefficients per block (optionally un-zigzagged) and presents each block as one wide word.
module idct_block_loader #(
   parameter int WIDTH  = 16,
   parameter int ZIGZAG = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    in_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_last,
   output logic [64*WIDTH-1:0] blk_data,
   output logic                blk_valid,
   input  logic                blk_ready,
   output logic [15:0]         blk_count
);

   function automatic logic [5:0] zz(input logic [5:0] k);
      case (k)
         6'd0:  zz = 6'd0;   6'd1:  zz = 6'd1;   6'd2:  zz = 6'd8;   6'd3:  zz = 6'd16;
         6'd4:  zz = 6'd9;   6'd5:  zz = 6'd2;   6'd6:  zz = 6'd3;   6'd7:  zz = 6'd10;
         6'd8:  zz = 6'd17;  6'd9:  zz = 6'd24;  6'd10: zz = 6'd32;  6'd11: zz = 6'd25;
         6'd12: zz = 6'd18;  6'd13: zz = 6'd11;  6'd14: zz = 6'd4;   6'd15: zz = 6'd5;
         6'd16: zz = 6'd12;  6'd17: zz = 6'd19;  6'd18: zz = 6'd26;  6'd19: zz = 6'd33;
         6'd20: zz = 6'd40;  6'd21: zz = 6'd48;  6'd22: zz = 6'd41;  6'd23: zz = 6'd34;
         6'd24: zz = 6'd27;  6'd25: zz = 6'd20;  6'd26: zz = 6'd13;  6'd27: zz = 6'd6;
         6'd28: zz = 6'd7;   6'd29: zz = 6'd14;  6'd30: zz = 6'd21;  6'd31: zz = 6'd28;
         6'd32: zz = 6'd35;  6'd33: zz = 6'd42;  6'd34: zz = 6'd49;  6'd35: zz = 6'd56;
         6'd36: zz = 6'd57;  6'd37: zz = 6'd50;  6'd38: zz = 6'd43;  6'd39: zz = 6'd36;
         6'd40: zz = 6'd29;  6'd41: zz = 6'd22;  6'd42: zz = 6'd15;  6'd43: zz = 6'd23;
         6'd44: zz = 6'd30;  6'd45: zz = 6'd37;  6'd46: zz = 6'd44;  6'd47: zz = 6'd51;
         6'd48: zz = 6'd58;  6'd49: zz = 6'd59;  6'd50: zz = 6'd52;  6'd51: zz = 6'd45;
         6'd52: zz = 6'd38;  6'd53: zz = 6'd31;  6'd54: zz = 6'd39;  6'd55: zz = 6'd46;
         6'd56: zz = 6'd53;  6'd57: zz = 6'd60;  6'd58: zz = 6'd61;  6'd59: zz = 6'd54;
         6'd60: zz = 6'd47;  6'd61: zz = 6'd55;  6'd62: zz = 6'd62;  default: zz = 6'd63;
      endcase
   endfunction

   logic [64*WIDTH-1:0] bank [2];
   logic [1:0]          full;
   logic                wr_bank;
   logic                rd_bank;
   logic [5:0]          idx;
   logic [5:0]          addr;
   logic                xfer;
   logic                handoff;
   logic                close;

   // Ready and valid come only from registered state, so blk_ready never reaches in_ready.
   assign in_ready  = ~full[wr_bank];
   assign blk_valid = full[rd_bank];
   assign blk_data  = bank[rd_bank];

   assign xfer    = in_valid & in_ready;
   assign handoff = blk_valid & blk_ready;
   assign close   = in_last | (idx == 6'd63);
   assign addr    = (ZIGZAG != 0) ? zz(idx) : idx;

   // A filling bank is never full and a handed-off bank always is, so the two updates never collide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank[0]   <= '0;
         bank[1]   <= '0;
         full      <= 2'b00;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         idx       <= 6'd0;
         blk_count <= 16'd0;
      end else begin
         if (handoff) begin
            bank[rd_bank] <= '0;
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            blk_count     <= blk_count + 16'd1;
         end
         if (xfer) begin
            bank[wr_bank][addr*WIDTH +: WIDTH] <= in_data;
            if (close) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
               idx           <= 6'd0;
            end else begin
               idx <= idx + 6'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_idct_block_loader.sv
// tb/tb_idct_block_loader.sv - bench for idct_block_loader
// Drives a natural-order and a zigzag instance with shared stimulus against a block-queue model.
module tb_idct_block_loader;

   typedef logic [64*16-1:0] blk_t;

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic        blk_ready;
   logic        rdy0, rdy1, v0, v1;
   blk_t        d0, d1;
   logic [15:0] cnt0, cnt1;

   int checks = 0;
   int errors = 0;

   idct_block_loader #(.WIDTH(16), .ZIGZAG(0)) u0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
      .in_last(in_last), .blk_data(d0), .blk_valid(v0), .blk_ready(blk_ready), .blk_count(cnt0));

   idct_block_loader #(.WIDTH(16), .ZIGZAG(1)) u1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
      .in_last(in_last), .blk_data(d1), .blk_valid(v1), .blk_ready(blk_ready), .blk_count(cnt1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int el(input blk_t d, input int i);
      return int'(d[i*16 +: 16]);
   endfunction

   // Zigzag order derived by walking the anti-diagonals of the 8x8 block.
   int zz_m [64];
   initial begin
      int k;
      k = 0;
      for (int s = 0; s < 15; s++) begin
         int lo, hi;
         lo = (s > 7) ? s - 7 : 0;
         hi = (s < 7) ? s : 7;
         if (s % 2 == 0) begin
            for (int r = hi; r >= lo; r--) begin zz_m[k] = r * 8 + (s - r); k++; end
         end else begin
            for (int r = lo; r <= hi; r++) begin zz_m[k] = r * 8 + (s - r); k++; end
         end
      end
   end

   blk_t        q0 [$];
   blk_t        q1 [$];
   blk_t        cur0, cur1;
   int          mk;
   logic [15:0] mcnt;

   task automatic blk_cmp(input string nm, input blk_t act, input blk_t exp);
      int bad;
      bad = -1;
      for (int i = 0; i < 64; i++)
         if (bad < 0 && act[i*16 +: 16] !== exp[i*16 +: 16]) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s: element %0d got %0d expected %0d", nm, bad, el(act, bad), el(exp, bad));
      end
   endtask

   // Check outputs against the model, then advance the model by the coming rising edge.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_blk_valid", int'(v0) + int'(v1), 0);
         chk("rst_blk_count", int'(cnt0) + int'(cnt1), 0);
         chk("rst_blk_data_nonzero", int'(d0 != '0) + int'(d1 != '0), 0);
         q0.delete(); q1.delete();
         cur0 = '0; cur1 = '0; mk = 0; mcnt = 16'd0;
      end else begin
         bit er, ev, xf, hd;
         er = (q0.size() < 2);
         ev = (q0.size() > 0);
         chk("in_ready_nat", int'(rdy0), int'(er));
         chk("in_ready_zz", int'(rdy1), int'(er));
         chk("blk_valid_nat", int'(v0), int'(ev));
         chk("blk_valid_zz", int'(v1), int'(ev));
         chk("blk_count_nat", int'(cnt0), int'(mcnt));
         chk("blk_count_zz", int'(cnt1), int'(mcnt));
         if (ev) begin
            blk_cmp("blk_data_nat", d0, q0[0]);
            blk_cmp("blk_data_zz", d1, q1[0]);
         end
         xf = in_valid && er;
         hd = ev && blk_ready;
         if (hd) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            mcnt = mcnt + 16'd1;
         end
         if (xf) begin
            cur0[mk*16 +: 16] = in_data;
            cur1[zz_m[mk]*16 +: 16] = in_data;
            mk++;
            if (in_last || mk == 64) begin
               q0.push_back(cur0);
               q1.push_back(cur1);
               cur0 = '0; cur1 = '0; mk = 0;
            end
         end
      end
   end

   task automatic send(input int v, input bit last);
      int  n;
      bit  acc;
      n = 0;
      in_data  = v[15:0];
      in_valid = 1'b1;
      in_last  = last;
      do begin
         @(negedge clk);
         acc = rdy0;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 500);
      if (!acc) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 'x;
   endtask

   task automatic send_block(input int base, input int n);
      for (int k = 0; k < n; k++) send(base + k, k == 63);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int nz;
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; blk_ready = 1'b1;
      cycles(3);
      rst = 1'b0;
      cycles(1);
      chk("post_reset_in_ready", int'(rdy0), 1);
      chk("post_reset_count", int'(cnt0), 0);

      // natural and zigzag ordering of k = 0..63
      send_block(0, 64);
      chk("t1_valid", int'(v0), 1);
      for (int i = 0; i < 64; i++) chk("t1_elem", el(d0, i), i);
      chk("t2_e0", el(d1, 0), 0);
      chk("t2_e1", el(d1, 1), 1);
      chk("t2_e8", el(d1, 8), 2);
      chk("t2_e16", el(d1, 16), 3);
      chk("t2_e2", el(d1, 2), 5);
      chk("t2_e63", el(d1, 63), 63);
      cycles(2);
      chk("t1_count", int'(cnt0), 1);

      // early end-of-block
      send(100, 1'b0);
      send(-3, 1'b0);
      send(7, 1'b1);
      chk("t3_valid", int'(v1), 1);
      chk("t3_e0", el(d1, 0), 100);
      chk("t3_e1", el(d1, 1), 16'hFFFD);
      chk("t3_e8", el(d1, 8), 7);
      chk("t3_nat_e2", el(d0, 2), 7);
      nz = 0;
      for (int i = 0; i < 64; i++)
         if (i != 0 && i != 1 && i != 8 && el(d1, i) != 0) nz++;
      chk("t3_zero_pad", nz, 0);
      cycles(2);

      // back-pressure with three blocks
      blk_ready = 1'b0;
      fork
         begin
            for (int b = 0; b < 3; b++) send_block(1000 + b * 64, 64);
         end
         begin
            int n;
            n = 0;
            do begin @(negedge clk); n++; end while (rdy0 && n < 400);
            chk("t4_ready_fell", int'(rdy0), 0);
            cycles(3);
            chk("t4_hold_valid", int'(v0), 1);
            chk("t4_hold_e0", el(d1, 0), 1000);
            blk_ready = 1'b1;
            cycles(1);
            blk_ready = 1'b0;
         end
      join
      cycles(2);
      chk("t4_block3_pending", int'(v0), 1);
      blk_ready = 1'b1;
      cycles(4);
      chk("t4_count", int'(cnt0), 5);
      chk("t4_drained", int'(v0), 0);

      // continuous streaming with simultaneous close and handoff
      for (int b = 0; b < 4; b++) send_block(2000 + b * 64, 64);
      cycles(2);
      chk("t5_count", int'(cnt1), 9);

      // reset mid-block with a pending full block
      blk_ready = 1'b0;
      send_block(3000, 64);
      send_block(4000, 30);
      chk("t6_pending", int'(v0), 1);
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", int'(v0), 0);
      chk("t6_rst_count", int'(cnt0), 0);
      chk("t6_rst_data_nonzero", int'(d0 != '0), 0);
      cycles(2);
      rst = 1'b0;
      blk_ready = 1'b1;
      send_block(500, 64);
      chk("t6_new_e0", el(d0, 0), 500);
      chk("t6_new_e63", el(d0, 63), 563);
      cycles(2);
      chk("t6_count", int'(cnt0), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
